// File: rtl/io_trap_ctrl_pkg.sv
// Shared definitions for the MegaMapper I/O trap controller: port addresses,
// control-register bit positions and the bus-cycle FSM state type.
package io_trap_ctrl_pkg;

  localparam logic [7:0]  CTRL_PORT_DEF  = 8'h30;
  localparam logic [7:0]  ISR_PORT_DEF   = 8'h31;
  localparam logic [7:0]  ALLOW_BASE_DEF = 8'h40;
  localparam logic [7:0]  ALLOW_MASK_DEF = 8'hF0;
  localparam int unsigned NMI_WIDTH_DEF  = 4;

  localparam int unsigned CTRL_TRAP_EN = 0;
  localparam int unsigned CTRL_NMI_EN  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PASS   = 3'd1,
    ST_OWN_WR = 3'd2,
    ST_OWN_RD = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  function automatic logic port_permitted(input logic [7:0] a,
                                          input logic [7:0] base,
                                          input logic [7:0] mask);
    return (a & mask) == base;
  endfunction

endpackage

// File: rtl/io_trap_ctrl_nmi_pulse_gen.sv
// Fixed-width active-low NMI pulse: a trigger loads a 4-bit down-counter and
// nmi_n stays low while the counter is non-zero.
module nmi_pulse_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  output logic nmi_n
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (trigger) begin
      cnt_q <= 4'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign nmi_n = (cnt_q == '0);

endmodule

// File: rtl/io_trap_ctrl.sv
// Z80 bus-cycle controller: decodes the mapper's own I/O ports, traps user-mode
// I/O outside the permitted window, and drives the capture/control strobes.
module io_trap_ctrl
  import io_trap_ctrl_pkg::*;
#(
  parameter logic [7:0]  CTRL_PORT  = CTRL_PORT_DEF,
  parameter logic [7:0]  ISR_PORT   = ISR_PORT_DEF,
  parameter logic [7:0]  ALLOW_BASE = ALLOW_BASE_DEF,
  parameter logic [7:0]  ALLOW_MASK = ALLOW_MASK_DEF,
  parameter int unsigned NMI_WIDTH  = NMI_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [3:0] ctrl,
  output logic       record_isr_en,
  output logic       read_isr_en,
  output logic       write_ctrl_en,
  output logic       io_violation_occured,
  output logic       io_suppress,
  output logic       nmi_n
);

  logic [7:0] s_addr;
  logic       s_iorq_n, s_m1_n, s_rd_n, s_wr_n;
  logic       s_trap_en, s_nmi_en;

  state_t state_q, state_d;
  logic   wr_d, rd_d, sup_d, flag_d, nmi_trig;

  logic s_io, s_iack, s_own;
  logic unused_ctrl_bits;

  assign unused_ctrl_bits = ^ctrl[3:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_addr    <= '0;
      s_iorq_n  <= 1'b1;
      s_m1_n    <= 1'b1;
      s_rd_n    <= 1'b1;
      s_wr_n    <= 1'b1;
      s_trap_en <= 1'b0;
      s_nmi_en  <= 1'b0;
    end else begin
      s_addr    <= addr;
      s_iorq_n  <= iorq_n;
      s_m1_n    <= m1_n;
      s_rd_n    <= rd_n;
      s_wr_n    <= wr_n;
      s_trap_en <= ctrl[CTRL_TRAP_EN];
      s_nmi_en  <= ctrl[CTRL_NMI_EN];
    end
  end

  assign s_io   = ~s_iorq_n &  s_m1_n;
  assign s_iack = ~s_iorq_n & ~s_m1_n;
  assign s_own  = (s_addr == CTRL_PORT) || (s_addr == ISR_PORT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= ST_IDLE;
      write_ctrl_en        <= 1'b0;
      read_isr_en          <= 1'b0;
      io_suppress          <= 1'b0;
      io_violation_occured <= 1'b0;
    end else begin
      state_q              <= state_d;
      write_ctrl_en        <= wr_d;
      read_isr_en          <= rd_d;
      io_suppress          <= sup_d;
      io_violation_occured <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = write_ctrl_en;
    rd_d     = read_isr_en;
    sup_d    = io_suppress;
    flag_d   = io_violation_occured;
    nmi_trig = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_io) begin
          if (s_addr == CTRL_PORT && !s_wr_n) begin
            state_d = ST_OWN_WR;
            wr_d    = 1'b1;
          end else if (s_addr == ISR_PORT && !s_rd_n) begin
            state_d = ST_OWN_RD;
            rd_d    = 1'b1;
          end else if (s_trap_en && !s_own &&
                       !port_permitted(s_addr, ALLOW_BASE, ALLOW_MASK)) begin
            state_d  = ST_TRAP;
            sup_d    = 1'b1;
            flag_d   = 1'b1;
            // Only the first violation raises NMI; later ones are just blocked.
            nmi_trig = s_nmi_en & ~io_violation_occured;
          end else begin
            state_d = ST_PASS;
          end
        end
      end
      default: begin
        if (s_iorq_n) begin
          state_d = ST_IDLE;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          sup_d   = 1'b0;
          if (state_q == ST_OWN_RD) begin
            flag_d = 1'b0;
          end
        end
      end
    endcase
  end

  // Frozen while a violation is pending so the offending opcode survives.
  assign record_isr_en = ~io_violation_occured & ~s_iack;

  nmi_pulse_gen #(
    .WIDTH(NMI_WIDTH)
  ) u_nmi (
    .clk    (clk),
    .reset_n(reset_n),
    .trigger(nmi_trig),
    .nmi_n  (nmi_n)
  );

endmodule

// File: tb/tb_io_trap_ctrl.sv
// Scoreboard bench for io_trap_ctrl: bus cycles push expected outcomes, a
// monitor collects the DUT's behaviour over each cycle and compares.
module tb_io_trap_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] addr = '0;
  logic       iorq_n = 1'b1, m1_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [3:0] ctrl = '0;
  logic       record_isr_en, read_isr_en, write_ctrl_en;
  logic       io_violation_occured, io_suppress, nmi_n;

  io_trap_ctrl dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .addr                (addr),
    .iorq_n              (iorq_n),
    .m1_n                (m1_n),
    .rd_n                (rd_n),
    .wr_n                (wr_n),
    .ctrl                (ctrl),
    .record_isr_en       (record_isr_en),
    .read_isr_en         (read_isr_en),
    .write_ctrl_en       (write_ctrl_en),
    .io_violation_occured(io_violation_occured),
    .io_suppress         (io_suppress),
    .nmi_n               (nmi_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sup, wen, ren;
    logic        flag_during, flag_after;
    logic        rec_at_r, rec_after;
    int unsigned nmi;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic flag_m = 1'b0;
  logic mon_en = 1'b0;
  logic busy = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: outcome of one bus cycle from the access rules alone.
  function automatic exp_t model(input logic [7:0] a, input bit wr, input bit iack,
                                 input logic [3:0] c);
    exp_t e;
    logic own, permitted, viol;
    e = '{default: 0};
    if (iack) begin
      e.flag_during = flag_m;
      e.flag_after  = flag_m;
      e.rec_at_r    = 1'b0;
      e.rec_after   = !flag_m;
      return e;
    end
    own       = (a == 8'h30) || (a == 8'h31);
    permitted = (a >= 8'h40) && (a <= 8'h4F);
    e.wen     = wr && (a == 8'h30);
    e.ren     = !wr && (a == 8'h31);
    viol      = c[0] && !own && !permitted;
    e.sup     = viol;
    e.nmi     = (viol && c[1] && !flag_m) ? 4 : 0;
    e.flag_during = flag_m | viol;
    e.flag_after  = e.ren ? 1'b0 : e.flag_during;
    e.rec_at_r    = !e.flag_during;
    e.rec_after   = !e.flag_after;
    flag_m = e.flag_after;
    return e;
  endfunction

  task automatic bus_cycle(input logic [7:0] a, input bit wr, input bit iack,
                           input logic [3:0] c, input int unsigned hold);
    q.push_back(model(a, wr, iack, c));
    @(negedge clk);
    addr   = a;
    ctrl   = c;
    iorq_n = 1'b0;
    if (iack) m1_n = 1'b0;
    else if (wr) wr_n = 1'b0;
    else rd_n = 1'b0;
    repeat (3) @(negedge clk);
    ctrl = 4'($urandom_range(0, 15));
    repeat (hold - 3) @(negedge clk);
    iorq_n = 1'b1;
    m1_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Monitor: k counts negedges from IORQ fall, r is the negedge IORQ rose.
  initial begin
    int          k, r;
    logic        a_sup, a_wen, a_ren, s_r1, s_r2, f_d, f_a, rc_r, rc_a;
    int unsigned n_cnt;
    exp_t        e;
    k = 0; r = -1;
    a_sup = 0; a_wen = 0; a_ren = 0; s_r1 = 0; s_r2 = 0;
    f_d = 0; f_a = 0; rc_r = 0; rc_a = 0; n_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (iorq_n == 1'b0) begin
          busy = 1'b1; k = 0; r = -1;
          a_sup = io_suppress; a_wen = write_ctrl_en; a_ren = read_isr_en;
          n_cnt = nmi_n ? 0 : 1;
        end
      end else begin
        k++;
        a_sup |= io_suppress;
        a_wen |= write_ctrl_en;
        a_ren |= read_isr_en;
        if (!nmi_n) n_cnt++;
        if (r < 0 && iorq_n == 1'b1) begin
          r    = k;
          f_d  = io_violation_occured;
          rc_r = record_isr_en;
        end
        if (r >= 0 && k == r + 1) s_r1 = write_ctrl_en | read_isr_en | io_suppress;
        if (r >= 0 && k == r + 2) begin
          s_r2 = write_ctrl_en | read_isr_en | io_suppress;
          f_a  = io_violation_occured;
          rc_a = record_isr_en;
        end
        if (r >= 0 && k == r + 4) begin
          busy = 1'b0;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got unexpected bus cycle, expected none queued");
          end else begin
            e = q.pop_front();
            check("io_suppress",          a_sup, e.sup);
            check("write_ctrl_en",        a_wen, e.wen);
            check("read_isr_en",          a_ren, e.ren);
            check("strobe_after_rise+1",  s_r1,  e.sup | e.wen | e.ren);
            check("strobe_after_rise+2",  s_r2,  1'b0);
            check("flag_during",          f_d,   e.flag_during);
            check("flag_after",           f_a,   e.flag_after);
            check("record_isr_during",    rc_r,  e.rec_at_r);
            check("record_isr_after",     rc_a,  e.rec_after);
            check("nmi_low_clocks",       n_cnt, e.nmi);
          end
        end else if (k > 200) begin
          busy = 1'b0;
          total++; bad++;
          $display("FAIL monitor_timeout: got no IORQ rise, expected one within 200 clocks");
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || busy); i++) @(negedge clk);
    check("drain_timeout", (q.size() != 0 || busy), 1'b0);
  endtask

  initial begin
    logic [7:0] a;
    logic [3:0] c;
    int unsigned sel;
    repeat (3) @(negedge clk);
    #1;
    check("reset_record_isr_en", record_isr_en, 1'b1);
    check("reset_nmi_n",         nmi_n,         1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("init_record_isr_en",  record_isr_en,        1'b1);
    check("init_read_isr_en",    read_isr_en,          1'b0);
    check("init_write_ctrl_en",  write_ctrl_en,        1'b0);
    check("init_flag",           io_violation_occured, 1'b0);
    check("init_io_suppress",    io_suppress,          1'b0);
    check("init_nmi_n",          nmi_n,                1'b1);
    mon_en = 1'b1;

    bus_cycle(8'h30, 1, 0, 4'h0, 4);   // OUT (30h): control write, trap off
    bus_cycle(8'h10, 1, 0, 4'h3, 4);   // violation with NMI
    bus_cycle(8'h45, 0, 0, 4'h3, 3);   // permitted window
    bus_cycle(8'h20, 1, 0, 4'h3, 4);   // second violation: no NMI
    bus_cycle(8'h00, 0, 1, 4'h3, 3);   // interrupt acknowledge
    bus_cycle(8'h31, 0, 0, 4'h3, 4);   // ISR read clears flag
    bus_cycle(8'h4F, 1, 0, 4'h3, 3);
    bus_cycle(8'h50, 0, 0, 4'h3, 3);   // just past window
    bus_cycle(8'h30, 0, 0, 4'h3, 3);   // IN (30h): own port, not trapped
    bus_cycle(8'h31, 0, 0, 4'h3, 3);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = 8'h30;
        2, 3:    a = 8'h31;
        4:       a = {4'h4, 4'($urandom_range(0, 15))};
        default: a = 8'($urandom_range(0, 255));
      endcase
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) c[0] = 1'b1;
      bus_cycle(a, bit'($urandom_range(0, 1)), sel == 5, c, $urandom_range(3, 6));
    end

    bus_cycle(8'h31, 0, 0, 4'h3, 3);
    drain();
    mon_en = 1'b0;

    @(negedge clk);
    addr   = 8'h10;
    ctrl   = 4'h3;
    iorq_n = 1'b0;
    wr_n   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pre_nmi_low",     nmi_n,       1'b0);
    check("rst_pre_io_suppress", io_suppress, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_nmi_n",       nmi_n,                1'b1);
    check("rst_mid_flag",        io_violation_occured, 1'b0);
    check("rst_mid_io_suppress", io_suppress,          1'b0);
    check("rst_mid_record_isr",  record_isr_en,        1'b1);
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
